reg_bus_arbiter: RTL
====================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for reg_rd_done before aborting a read (range 1..255).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned when a read times out.
REQ-003 SHALL have port clk_25mhz  input  1  single clock for all state.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_req/m1_req  input  1  each requester's request, held high until its ack.
REQ-006 SHALL have ports m0_we/m1_we  input  1  1 = write, 0 = read; valid while req is high.
REQ-007 SHALL have ports m0_addr/m1_addr  input  8  register address.
REQ-008 SHALL have ports m0_wdata/m1_wdata  input  32  write data.
REQ-009 SHALL have ports m0_ack/m1_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports m0_rdata/m1_rdata  output  32  read data, valid when ack is high.
REQ-011 SHALL have ports m0_err/m1_err  output  1  timeout flag, valid when ack is high.
REQ-012 SHALL have ports reg_addr (output, 8) and reg_wr_data (output, 32): target address and write data.
REQ-013 SHALL have ports reg_wr_en/reg_rd_en  output  1  one-cycle target strobes.
REQ-014 SHALL have ports reg_rd_data (input, 32) and reg_rd_done (input, 1): target read response.
REQ-015 SHALL have ports busy (output, 1: state != IDLE) and grant_id (output, 1: requester owning the current or last transaction).

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: when any req is high, SHALL choose a winner, latch its we/addr/wdata into the target-side registers, set grant_id to the winner and go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: if both req are high, the requester not equal to grant_id wins; if one req is high, it wins.
REQ-019 ISSUE SHALL last exactly one cycle, asserting reg_wr_en (write) or reg_rd_en (read) with latched reg_addr/reg_wr_data.
REQ-020 Write: ISSUE -> RESP; ack SHALL appear 2 cycles after the IDLE sampling cycle, with err = 0 and rdata = 0.
REQ-021 Read: reg_rd_done sampled high in ISSUE or WAIT SHALL capture reg_rd_data into the granted rdata register and go to RESP with err = 0.
REQ-022 Read without done: ISSUE -> WAIT; an 8-bit counter SHALL clear in ISSUE and increment each WAIT cycle.
REQ-023 When the count reaches TIMEOUT_CYCLES without done, the read SHALL abort: rdata = ERR_DATA, err = 1, go to RESP.
REQ-024 If done arrives in the same cycle the count reaches TIMEOUT_CYCLES, done SHALL take priority (err = 0).
REQ-025 RESP SHALL pulse the ack of the granted requester only, for one cycle, then go to IDLE; the other requester's ack SHALL stay 0.
REQ-026 A requester SHALL drop req on the edge where it samples ack; the arbiter SHALL be able to accept a new request in the IDLE cycle that follows.
REQ-027 reg_rd_done in IDLE or RESP SHALL be ignored (late response after timeout is discarded).
REQ-028 req deasserted before ack SHALL NOT abort the transaction; it completes and ack still pulses.
REQ-029 rdata/err SHALL hold their value until the next completion for that requester.
REQ-030 Target strobes SHALL never both be high, and SHALL be high only in ISSUE.

Reset
REQ-031 While rst_i = 0: state = IDLE, grant_id = 1 (so m0 wins the first tie), counter = 0, all outputs = 0.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately with no ack; after release the FSM starts from IDLE.

Verification
REQ-033 m0 write (addr 8'h10, data 32'h1234_5678) -> reg_wr_en high for 1 cycle with those values; m0_ack 2 cycles after the req was sampled; err = 0.
REQ-034 m1 read with target rd_done 3 cycles after reg_rd_en, rd_data 32'hCAFE_F00D -> m1_rdata = 32'hCAFE_F00D, m1_err = 0, m1_ack one cycle after done.
REQ-035 Both requesters reading continuously after reset -> grants alternate m0, m1, m0, m1; no ack to the wrong requester.
REQ-036 Read with no rd_done, TIMEOUT_CYCLES = 4 -> ack with rdata 32'hDEAD_BEEF and err = 1; a later stray rd_done is ignored and busy = 0.
REQ-037 rd_done in the same cycle as the timeout -> target data returned, err = 0.
REQ-038 rst_i low during WAIT -> outputs 0 immediately, no ack; after release, the first tie goes to m0.

Source files
------------

// File: rtl/reg_bus_arbiter_if.sv
// Requester and register-target signals of the two-master register bus arbiter.
// master: the arbiter's view; slave: the view of the requesters and the target.
interface reg_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [7:0]  m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m0_err;

    logic        m1_req;
    logic        m1_we;
    logic [7:0]  m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic [7:0]  reg_addr;
    logic [31:0] reg_wr_data;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data;
    logic        reg_rd_done;

    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output reg_addr, reg_wr_data, reg_wr_en, reg_rd_en,
        input  reg_rd_data, reg_rd_done
    );

    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  reg_addr, reg_wr_data, reg_wr_en, reg_rd_en,
        output reg_rd_data, reg_rd_done
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register target between two requesters,
// with a bounded wait for read completion and an error response on timeout.
module reg_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic              clk_25mhz,
    input  logic              rst_i,
    reg_bus_arbiter_if.master bus,
    output logic              busy,
    output logic              grant_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

    state_t      state_reg, state_next;
    logic        grant_reg, grant_next;
    logic        we_reg, we_next;
    logic [7:0]  addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        win;
    logic        cap_en;
    logic [31:0] cap_data;
    logic        cap_err;

    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [1:0][7:0]   addr_vec;
    logic [1:0][31:0]  wdata_vec;
    logic [1:0][31:0]  rdata_vec;
    logic [1:0]        err_vec;
    logic [1:0]        ack_vec;

    assign req_vec   = {bus.m1_req, bus.m0_req};
    assign we_vec    = {bus.m1_we, bus.m0_we};
    assign addr_vec  = {bus.m1_addr, bus.m0_addr};
    assign wdata_vec = {bus.m1_wdata, bus.m0_wdata};

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        win        = grant_reg;
        cap_en     = 1'b0;
        cap_data   = '0;
        cap_err    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_vec != 2'b00) begin
                    // On a tie the requester that did not own the last transaction wins.
                    win        = (req_vec == 2'b11) ? ~grant_reg : req_vec[1];
                    grant_next = win;
                    we_next    = we_vec[win];
                    addr_next  = addr_vec[win];
                    wdata_next = wdata_vec[win];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next = '0;
                if (we_reg) begin
                    cap_en     = 1'b1;
                    state_next = RESP;
                end else if (bus.reg_rd_done) begin
                    cap_en     = 1'b1;
                    cap_data   = bus.reg_rd_data;
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Abort after TIMEOUT_CYCLES WAIT cycles; done in the last one still wins.
                cnt_next = cnt_reg + 8'd1;
                if (bus.reg_rd_done) begin
                    cap_en     = 1'b1;
                    cap_data   = bus.reg_rd_data;
                    state_next = RESP;
                end else if (cnt_next == TIMEOUT_VAL) begin
                    cap_en     = 1'b1;
                    cap_data   = ERR_DATA;
                    cap_err    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            grant_reg <= 1'b1;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Per-requester response registers, updated only by that requester's completions.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            localparam logic ID = 1'(gi);
            logic [31:0] rdata_reg;
            logic        err_reg;

            always_ff @(posedge clk_25mhz or negedge rst_i) begin
                if (!rst_i) begin
                    rdata_reg <= '0;
                    err_reg   <= 1'b0;
                end else if (cap_en && (grant_reg == ID)) begin
                    rdata_reg <= cap_data;
                    err_reg   <= cap_err;
                end
            end

            assign rdata_vec[gi] = rdata_reg;
            assign err_vec[gi]   = err_reg;
            assign ack_vec[gi]   = (state_reg == RESP) && (grant_reg == ID);
        end
    endgenerate

    assign bus.m0_ack      = ack_vec[0];
    assign bus.m1_ack      = ack_vec[1];
    assign bus.m0_rdata    = rdata_vec[0];
    assign bus.m1_rdata    = rdata_vec[1];
    assign bus.m0_err      = err_vec[0];
    assign bus.m1_err      = err_vec[1];
    assign bus.reg_addr    = addr_reg;
    assign bus.reg_wr_data = wdata_reg;
    assign bus.reg_wr_en   = (state_reg == ISSUE) && we_reg;
    assign bus.reg_rd_en   = (state_reg == ISSUE) && !we_reg;
    assign busy            = (state_reg != IDLE);
    assign grant_id        = grant_reg;
endmodule
